// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the seven-segment scan driver.
// Segment codes are active-low: bit 7 = dp, bits 6..0 = g..a.
package seg7_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'hFF;

    localparam seg_t GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic seg_t hex_to_seg(
        input logic [3:0] nib,
        input logic       dp
    );
        seg_t s;
        s    = GLYPH[nib];
        s[7] = ~dp;
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_tick.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1 and flags the slot end,
// the slot start and the end of the anti-ghosting guard interval.
module seg7_scan_tick #(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 16
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick,
    output logic cnt_ge_guard,
    output logic cnt_zero
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick     = (cnt == CW'(SCAN_DIV - 1));
    assign cnt_zero = (cnt == '0);

    generate
        if (GUARD == 0) begin : g_noguard
            assign cnt_ge_guard = 1'b1;
        end else begin : g_guard
            assign cnt_ge_guard = (cnt >= CW'(GUARD));
        end
    endgenerate

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NDIGITS seven-segment driver with double-buffered
// contents, leading-zero suppression and a per-slot guard interval.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4*NDIGITS-1:0] value,
    input  logic [NDIGITS-1:0]   dp,
    input  logic [NDIGITS-1:0]   blank,
    input  logic                 lz_suppress,
    input  logic                 load,
    output logic [7:0]           leds,
    output logic [NDIGITS-1:0]   ct,
    output logic                 frame_start
);

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int VW = 4 * NDIGITS;

    logic [VW-1:0]      pend_val, act_val;
    logic [NDIGITS-1:0] pend_dp, act_dp;
    logic [NDIGITS-1:0] pend_blank, act_blank;
    logic               pend_lz, act_lz;
    logic [IW-1:0]      idx;
    logic               tick, cnt_ge_guard, cnt_zero, last;

    seg7_scan_tick #(
        .SCAN_DIV (SCAN_DIV),
        .GUARD    (GUARD)
    ) u_tick (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .cnt_ge_guard (cnt_ge_guard),
        .cnt_zero     (cnt_zero)
    );

    assign last = (idx == IW'(NDIGITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_lz    <= 1'b0;
        end else if (load) begin
            pend_val   <= value;
            pend_dp    <= dp;
            pend_blank <= blank;
            pend_lz    <= lz_suppress;
        end
    end

    // Copy only at the frame boundary so a frame never mixes contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_val   <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            act_lz    <= 1'b0;
        end else if (tick && last) begin
            act_val   <= pend_val;
            act_dp    <= pend_dp;
            act_blank <= pend_blank;
            act_lz    <= pend_lz;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

    // tz[g]: nibbles g..NDIGITS-1 are all zero.
    logic [NDIGITS:1]   tz;
    logic [NDIGITS-1:0] dark;
    seg_t               code [NDIGITS];

    assign tz[NDIGITS] = 1'b1;

    generate
        for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
            if (g == 0) begin : g_lsd
                assign dark[g] = act_blank[g];
            end else begin : g_upper
                assign tz[g]   = tz[g+1] & (act_val[4*g +: 4] == 4'h0);
                assign dark[g] = act_blank[g] | (act_lz & tz[g]);
            end
            assign code[g] = dark[g] ? SEG_BLANK
                           : hex_to_seg(act_val[4*g +: 4], act_dp[g]);
        end
    endgenerate

    seg_t               cur_seg;
    logic [NDIGITS-1:0] cur_oh;

    always_comb begin
        cur_seg = SEG_BLANK;
        cur_oh  = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_seg   = code[i];
                cur_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leds        <= SEG_BLANK;
            ct          <= '0;
            frame_start <= 1'b0;
        end else begin
            leds        <= cur_seg;
            ct          <= cnt_ge_guard ? cur_oh : '0;
            frame_start <= (idx == '0) && cnt_zero;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with NDIGITS=4, SCAN_DIV=4, GUARD=1.
module tb_seg7_scan_driver;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_suppress;
    logic        load;
    logic [7:0]  leds;
    logic [3:0]  ct;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] cur_exp;

    seg7_scan_driver #(
        .NDIGITS  (ND),
        .SCAN_DIV (4),
        .GUARD    (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .value       (value),
        .dp          (dp),
        .blank       (blank),
        .lz_suppress (lz_suppress),
        .load        (load),
        .leds        (leds),
        .ct          (ct),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Segments g..a, active-low, for each hex digit.
    function automatic logic [6:0] glyph7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [31:0] model(
        input logic [15:0] v,
        input logic [3:0]  dpm,
        input logic [3:0]  bl,
        input logic        lz
    );
        logic [31:0] r;
        logic        tail;
        logic        drk;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            tail = 1'b1;
            for (int j = i; j < ND; j++)
                if (v[4*j +: 4] != 4'h0) tail = 1'b0;
            drk = bl[i] | (lz && (i > 0) && tail);
            r[8*i +: 8] = drk ? 8'hFF : {~dpm[i], glyph7(v[4*i +: 4])};
        end
        return r;
    endfunction

    task automatic wait_fs(output int n);
        n = -1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic check_frame(input string name, output int n);
        logic [31:0] e;
        logic [3:0]  ect;
        int          d;
        e = exp_q.pop_front();
        wait_fs(n);
        if (n < 0) begin
            checks++;
            errors++;
            $display("FAIL %s frame_start timeout", name);
            return;
        end
        for (int s = 0; s < 16; s++) begin
            if (s > 0) @(negedge clk);
            d   = s / 4;
            ect = ((s % 4) >= 1) ? (4'b0001 << d) : 4'b0000;
            checks++;
            if (leds !== e[8*d +: 8]) begin
                errors++;
                $display("FAIL %s leds slot %0d got %h exp %h",
                         name, s, leds, e[8*d +: 8]);
            end
            checks++;
            if (ct !== ect) begin
                errors++;
                $display("FAIL %s ct slot %0d got %b exp %b",
                         name, s, ct, ect);
            end
            checks++;
            if (frame_start !== (s == 0)) begin
                errors++;
                $display("FAIL %s frame_start slot %0d got %b exp %b",
                         name, s, frame_start, (s == 0));
            end
        end
    endtask

    task automatic do_load(
        input logic [15:0] v,
        input logic [3:0]  d,
        input logic [3:0]  b,
        input logic        lz
    );
        value       = v;
        dp          = d;
        blank       = b;
        lz_suppress = lz;
        load        = 1'b1;
        @(negedge clk);
        load        = 1'b0;
    endtask

    task automatic load_and_check(
        input string       name,
        input logic [15:0] v,
        input logic [3:0]  d,
        input logic [3:0]  b,
        input logic        lz
    );
        int n;
        wait_fs(n);
        do_load(v, d, b, lz);
        cur_exp = model(v, d, b, lz);
        exp_q.push_back(cur_exp);
        check_frame(name, n);
    endtask

    task automatic test_reset();
        int n;
        reset_n     = 1'b0;
        load        = 1'b0;
        value       = '0;
        dp          = '0;
        blank       = '0;
        lz_suppress = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (leds !== 8'hFF || ct !== 4'h0 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold got %h/%b/%b exp FF/0000/0",
                         leds, ct, frame_start);
            end
        end
        reset_n = 1'b1;
        cur_exp = model(16'h0000, 4'h0, 4'h0, 1'b0);
        exp_q.push_back(cur_exp);
        check_frame("reset_frame", n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL reset_first_fs got %0d exp 1", n);
        end
        @(negedge clk);
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL fs_period got %b exp 1", frame_start);
        end
    endtask

    task automatic test_basic_decode();
        load_and_check("basic", 16'h1A2F, 4'b0010, 4'b0000, 1'b0);
    endtask

    task automatic test_lz_suppress();
        load_and_check("lz_0050", 16'h0050, 4'b1000, 4'b0000, 1'b1);
        load_and_check("lz_0000", 16'h0000, 4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic test_blank_dp();
        load_and_check("blank_dp", 16'h8888, 4'b0010, 4'b0010, 1'b0);
    endtask

    task automatic test_mid_frame_load();
        int          n;
        int          d;
        logic [31:0] nxt;
        wait_fs(n);
        repeat (8) @(negedge clk);
        value       = 16'h0003;
        dp          = 4'b0000;
        blank       = 4'b0000;
        lz_suppress = 1'b0;
        load        = 1'b1;
        nxt         = model(16'h0003, 4'b0000, 4'b0000, 1'b0);
        for (int s = 8; s < 16; s++) begin
            if (s > 8) @(negedge clk);
            if (s == 9) load = 1'b0;
            d = s / 4;
            checks++;
            if (leds !== cur_exp[8*d +: 8]) begin
                errors++;
                $display("FAIL midload_old slot %0d got %h exp %h",
                         s, leds, cur_exp[8*d +: 8]);
            end
        end
        cur_exp = nxt;
        exp_q.push_back(cur_exp);
        check_frame("midload_new", n);
    endtask

    task automatic test_back_to_back();
        int          n;
        logic [31:0] nxt;
        wait_fs(n);
        repeat (14) @(negedge clk);
        do_load(16'hBEEF, 4'b0101, 4'b0000, 1'b0);
        nxt = model(16'hBEEF, 4'b0101, 4'b0000, 1'b0);
        exp_q.push_back(cur_exp);
        exp_q.push_back(nxt);
        check_frame("coincide_old", n);
        check_frame("coincide_new", n);
        cur_exp = nxt;
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [3:0]  d;
        logic [3:0]  b;
        logic        lz;
        for (int i = 0; i < 3; i++) begin
            v  = 16'($urandom);
            d  = 4'($urandom);
            b  = 4'($urandom) & 4'($urandom);
            lz = 1'($urandom);
            if (i == 0) v[15:8] = 8'h00;
            load_and_check("random", v, d, b, lz);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        wait_fs(n);
        repeat (12) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (leds !== 8'hFF || ct !== 4'h0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %h/%b/%b exp FF/0000/0",
                     leds, ct, frame_start);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cur_exp = model(16'h0000, 4'h0, 4'h0, 1'b0);
        exp_q.push_back(cur_exp);
        check_frame("reset_mid", n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL reset_mid_first_fs got %0d exp 1", n);
        end
    endtask

    initial begin
        test_reset();
        test_basic_decode();
        test_lz_suppress();
        test_blank_dp();
        test_mid_frame_load();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
